// File: rtl/mem_stage.sv
// Memory stage: data-memory load/store, branch resolve, MEM/WB pipeline register.
// A multi-cycle memory is modelled by a small IDLE/BUSY FSM that raises stall upstream.
module mem_stage #(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Mem_WB,
  input  logic        read_En,
  input  logic        write_En,
  input  logic        Mem_Br,
  input  logic        Zero,
  input  logic [31:0] DataAddress,
  input  logic [31:0] WriteData,
  input  logic [4:0]  dest,
  output logic [1:0]  WB_ctrl,
  output logic [31:0] ReadData,
  output logic [31:0] ALUResult,
  output logic [4:0]  Write_Register,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        PCSrc,
  output logic        stall,
  output logic        misalign
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mem [DEPTH];

  logic [AW-1:0] idx;
  logic          access, aligned, req, mis_idle, done;
  logic          unused_addr_hi;

  // Upper address bits are deliberately dropped so addresses wrap modulo DEPTH*4.
  assign idx            = DataAddress[AW+1:2];
  assign unused_addr_hi = ^DataAddress[31:AW+2];
  assign access         = read_En | write_En;
  assign aligned        = (DataAddress[1:0] == 2'b00);
  assign req            = access & aligned;
  assign mis_idle       = access & ~aligned & (state_q == IDLE);
  assign PCSrc          = Mem_Br & Zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req && MEM_LAT > 1) begin
        state_d = BUSY;
        cnt_d   = CNT_INIT;
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        if (MEM_LAT == 1) done  = 1'b1;
        else              stall = 1'b1;
      end
      BUSY: begin
        if (cnt_q == CNT_ONE) done  = 1'b1;
        else                  stall = 1'b1;
      end
      default: ;
    endcase
  end

  // Data memory is not reset; a store is only committed on its completion edge.
  always_ff @(posedge clk) begin
    if (done && write_En && !rst) mem[idx] <= WriteData;
  end

  // ---- MEM/WB boundary ----
  logic [1:0]  wb_ctrl_p1;
  logic [31:0] read_data_p1, alu_result_p1;
  logic [4:0]  write_reg_p1;
  logic        misalign_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ctrl_p1    <= '0;
      read_data_p1  <= '0;
      alu_result_p1 <= '0;
      write_reg_p1  <= '0;
      misalign_p1   <= 1'b0;
    end else begin
      misalign_p1 <= mis_idle;
      if (stall) begin
        wb_ctrl_p1 <= '0;
      end else begin
        wb_ctrl_p1    <= {Mem_WB[1] & ~mis_idle, Mem_WB[0]};
        alu_result_p1 <= DataAddress;
        write_reg_p1  <= dest;
      end
      if (done && read_En) read_data_p1 <= mem[idx];
    end
  end

  assign WB_ctrl        = wb_ctrl_p1;
  assign ReadData       = read_data_p1;
  assign ALUResult      = alu_result_p1;
  assign Write_Register = write_reg_p1;
  assign misalign       = misalign_p1;
  assign RegWrite       = wb_ctrl_p1[1];
  assign MemtoReg       = wb_ctrl_p1[0];

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances (latency 1, 3, 4) share one stimulus bus.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  Mem_WB;
  logic        read_En, write_En, Mem_Br, Zero;
  logic [31:0] DataAddress, WriteData;
  logic [4:0]  dest;

  logic [1:0]  o1_wb, o3_wb, o4_wb;
  logic [31:0] o1_rd, o3_rd, o4_rd, o1_alu, o3_alu, o4_alu;
  logic [4:0]  o1_wr, o3_wr, o4_wr;
  logic        o1_rw, o3_rw, o4_rw, o1_m2r, o3_m2r, o4_m2r;
  logic        o1_pc, o3_pc, o4_pc, o1_st, o3_st, o4_st, o1_mis, o3_mis, o4_mis;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.DEPTH(1024), .AW(10), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst), .Mem_WB(Mem_WB), .read_En(read_En), .write_En(write_En),
    .Mem_Br(Mem_Br), .Zero(Zero), .DataAddress(DataAddress), .WriteData(WriteData), .dest(dest),
    .WB_ctrl(o1_wb), .ReadData(o1_rd), .ALUResult(o1_alu), .Write_Register(o1_wr),
    .RegWrite(o1_rw), .MemtoReg(o1_m2r), .PCSrc(o1_pc), .stall(o1_st), .misalign(o1_mis));

  mem_stage #(.DEPTH(1024), .AW(10), .MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst), .Mem_WB(Mem_WB), .read_En(read_En), .write_En(write_En),
    .Mem_Br(Mem_Br), .Zero(Zero), .DataAddress(DataAddress), .WriteData(WriteData), .dest(dest),
    .WB_ctrl(o3_wb), .ReadData(o3_rd), .ALUResult(o3_alu), .Write_Register(o3_wr),
    .RegWrite(o3_rw), .MemtoReg(o3_m2r), .PCSrc(o3_pc), .stall(o3_st), .misalign(o3_mis));

  mem_stage #(.DEPTH(1024), .AW(10), .MEM_LAT(4)) u4 (
    .clk(clk), .rst(rst), .Mem_WB(Mem_WB), .read_En(read_En), .write_En(write_En),
    .Mem_Br(Mem_Br), .Zero(Zero), .DataAddress(DataAddress), .WriteData(WriteData), .dest(dest),
    .WB_ctrl(o4_wb), .ReadData(o4_rd), .ALUResult(o4_alu), .Write_Register(o4_wr),
    .RegWrite(o4_rw), .MemtoReg(o4_m2r), .PCSrc(o4_pc), .stall(o4_st), .misalign(o4_mis));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    Mem_WB = 2'b00; read_En = 1'b0; write_En = 1'b0; Mem_Br = 1'b0; Zero = 1'b0;
    DataAddress = 32'h0; WriteData = 32'h0; dest = 5'd0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    tick();
    checks++; if (o1_wb !== 2'b00) begin errors++; $display("FAIL rst_wb: got %h expected 0", o1_wb); end
    checks++; if (o1_rd !== 32'h0) begin errors++; $display("FAIL rst_rd: got %h expected 0", o1_rd); end
    checks++; if (o1_alu !== 32'h0) begin errors++; $display("FAIL rst_alu: got %h expected 0", o1_alu); end
    checks++; if (o1_wr !== 5'd0) begin errors++; $display("FAIL rst_wr: got %h expected 0", o1_wr); end
    checks++; if (o1_mis !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b expected 0", o1_mis); end
    checks++; if (o3_st !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", o3_st); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_cycle();
    do_reset();
    write_En = 1'b1; DataAddress = 32'h10; WriteData = 32'hDEADBEEF; Mem_WB = 2'b10; dest = 5'd5;
    #1;
    checks++; if (o1_st !== 1'b0) begin errors++; $display("FAIL sc_stall_st: got %b expected 0", o1_st); end
    tick();
    checks++; if (o1_wb !== 2'b10) begin errors++; $display("FAIL sc_wb_st: got %b expected 10", o1_wb); end
    write_En = 1'b0; read_En = 1'b1; Mem_WB = 2'b11; dest = 5'd7;
    #1;
    checks++; if (o1_st !== 1'b0) begin errors++; $display("FAIL sc_stall_ld: got %b expected 0", o1_st); end
    tick();
    idle_in();
    checks++; if (o1_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL sc_rd: got %h expected deadbeef", o1_rd); end
    checks++; if (o1_wb !== 2'b11) begin errors++; $display("FAIL sc_wb_ld: got %b expected 11", o1_wb); end
    checks++; if (o1_rw !== 1'b1 || o1_m2r !== 1'b1) begin errors++; $display("FAIL sc_rw_m2r: got %b%b expected 11", o1_rw, o1_m2r); end
    checks++; if (o1_wr !== 5'd7) begin errors++; $display("FAIL sc_wr: got %0d expected 7", o1_wr); end
    tick();
    checks++; if (o1_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL sc_rd_hold: got %h expected deadbeef", o1_rd); end
  endtask

  task automatic test_multi_cycle();
    do_reset();
    write_En = 1'b1; DataAddress = 32'h20; WriteData = 32'hCAFEF00D;
    #1;
    checks++; if (o3_st !== 1'b1) begin errors++; $display("FAIL mc_st_c0: got %b expected 1", o3_st); end
    tick();
    checks++; if (o3_st !== 1'b1) begin errors++; $display("FAIL mc_st_c1: got %b expected 1", o3_st); end
    tick();
    checks++; if (o3_st !== 1'b0) begin errors++; $display("FAIL mc_st_c2: got %b expected 0", o3_st); end
    tick();
    idle_in();
    read_En = 1'b1; DataAddress = 32'h20; Mem_WB = 2'b11; dest = 5'd9; Mem_Br = 1'b1; Zero = 1'b1;
    #1;
    checks++; if (o3_st !== 1'b1) begin errors++; $display("FAIL mc_ld_st0: got %b expected 1", o3_st); end
    checks++; if (o3_pc !== 1'b1) begin errors++; $display("FAIL mc_pcsrc_busy: got %b expected 1", o3_pc); end
    tick();
    checks++; if (o3_st !== 1'b1) begin errors++; $display("FAIL mc_ld_st1: got %b expected 1", o3_st); end
    checks++; if (o3_wb !== 2'b00) begin errors++; $display("FAIL mc_bubble1: got %b expected 00", o3_wb); end
    tick();
    checks++; if (o3_st !== 1'b0) begin errors++; $display("FAIL mc_ld_st2: got %b expected 0", o3_st); end
    checks++; if (o3_wb !== 2'b00) begin errors++; $display("FAIL mc_bubble2: got %b expected 00", o3_wb); end
    checks++; if (o3_rd !== 32'h0) begin errors++; $display("FAIL mc_rd_early: got %h expected 0", o3_rd); end
    tick();
    idle_in();
    checks++; if (o3_rd !== 32'hCAFEF00D) begin errors++; $display("FAIL mc_rd: got %h expected cafef00d", o3_rd); end
    checks++; if (o3_wb !== 2'b11) begin errors++; $display("FAIL mc_wb: got %b expected 11", o3_wb); end
    checks++; if (o3_wr !== 5'd9) begin errors++; $display("FAIL mc_wr: got %0d expected 9", o3_wr); end
  endtask

  task automatic test_misalign();
    do_reset();
    write_En = 1'b1; DataAddress = 32'h13; WriteData = 32'hFFFFFFFF; Mem_WB = 2'b11; dest = 5'd3;
    #1;
    checks++; if (o1_st !== 1'b0 || o3_st !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b%b expected 00", o1_st, o3_st); end
    tick();
    idle_in();
    checks++; if (o1_mis !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b expected 1", o1_mis); end
    checks++; if (o1_rw !== 1'b0 || o1_m2r !== 1'b1) begin errors++; $display("FAIL mis_wb: got %b%b expected 01", o1_rw, o1_m2r); end
    checks++; if (o3_mis !== 1'b1 || o3_wb !== 2'b01) begin errors++; $display("FAIL mis_lat3: got %b/%b expected 1/01", o3_mis, o3_wb); end
    checks++; if (o1_alu !== 32'h13) begin errors++; $display("FAIL mis_alu: got %h expected 13", o1_alu); end
    tick();
    checks++; if (o1_mis !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %b expected 0", o1_mis); end
    read_En = 1'b1; DataAddress = 32'h10; Mem_WB = 2'b11;
    tick();
    idle_in();
    checks++; if (o1_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_mem_kept: got %h expected deadbeef", o1_rd); end
  endtask

  task automatic test_wrap();
    do_reset();
    write_En = 1'b1; DataAddress = 32'h1000; WriteData = 32'h55;
    tick();
    write_En = 1'b0; read_En = 1'b1; DataAddress = 32'h0;
    tick();
    idle_in();
    checks++; if (o1_rd !== 32'h55) begin errors++; $display("FAIL wrap_rd: got %h expected 55", o1_rd); end
  endtask

  task automatic test_branch_passthru();
    do_reset();
    Mem_Br = 1'b1; Zero = 1'b1; DataAddress = 32'hABCD0; dest = 5'd12; Mem_WB = 2'b10;
    #1;
    checks++; if (o1_pc !== 1'b1) begin errors++; $display("FAIL br_taken: got %b expected 1", o1_pc); end
    Zero = 1'b0;
    #1;
    checks++; if (o1_pc !== 1'b0) begin errors++; $display("FAIL br_zero0: got %b expected 0", o1_pc); end
    Mem_Br = 1'b0; Zero = 1'b1;
    #1;
    checks++; if (o1_pc !== 1'b0) begin errors++; $display("FAIL br_nobr: got %b expected 0", o1_pc); end
    tick();
    checks++; if (o1_alu !== 32'hABCD0 || o3_alu !== 32'hABCD0) begin errors++; $display("FAIL pt_alu: got %h/%h expected abcd0", o1_alu, o3_alu); end
    checks++; if (o1_wr !== 5'd12) begin errors++; $display("FAIL pt_wr: got %0d expected 12", o1_wr); end
    checks++; if (o1_wb !== 2'b10) begin errors++; $display("FAIL pt_wb: got %b expected 10", o1_wb); end
    DataAddress = 32'h777; dest = 5'd31; Mem_WB = 2'b01;
    tick();
    idle_in();
    checks++; if (o1_alu !== 32'h777 || o1_wr !== 5'd31) begin errors++; $display("FAIL pt_2: got %h/%0d expected 777/31", o1_alu, o1_wr); end
  endtask

  task automatic test_reset_busy();
    do_reset();
    write_En = 1'b1; DataAddress = 32'h40; WriteData = 32'h12345678; Mem_WB = 2'b11; dest = 5'd4;
    #1;
    checks++; if (o4_st !== 1'b1) begin errors++; $display("FAIL rb_st0: got %b expected 1", o4_st); end
    tick();
    tick();
    checks++; if (o4_st !== 1'b1) begin errors++; $display("FAIL rb_st2: got %b expected 1", o4_st); end
    tick();
    checks++; if (o4_st !== 1'b0) begin errors++; $display("FAIL rb_st3: got %b expected 0", o4_st); end
    tick();
    idle_in();
    checks++; if (o4_alu !== 32'h40 || o4_wb !== 2'b11) begin errors++; $display("FAIL rb_done: got %h/%b expected 40/11", o4_alu, o4_wb); end
    write_En = 1'b1; DataAddress = 32'h40; WriteData = 32'h99999999; Mem_WB = 2'b11; dest = 5'd8;
    tick();
    tick();
    #1;
    idle_in();
    rst = 1'b1;
    #1;
    checks++; if (o4_st !== 1'b0) begin errors++; $display("FAIL rb_rst_stall: got %b expected 0", o4_st); end
    checks++; if (o4_wb !== 2'b00 || o4_alu !== 32'h0 || o4_wr !== 5'd0) begin errors++; $display("FAIL rb_rst_out: got %b/%h/%0d expected 0/0/0", o4_wb, o4_alu, o4_wr); end
    #2;
    rst = 1'b0;
    tick();
    read_En = 1'b1; DataAddress = 32'h40;
    for (int i = 0; i < 4; i++) tick();
    idle_in();
    checks++; if (o4_rd !== 32'h12345678) begin errors++; $display("FAIL rb_mem_kept: got %h expected 12345678", o4_rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    idle_in();
    test_reset();
    test_single_cycle();
    test_multi_cycle();
    test_misalign();
    test_wrap();
    test_branch_passthru();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
